spi_shift_register: RTL
=======================

# spi_shift_register

Serial data path of the APB SPI master core. Sits directly downstream of the baud-rate generator: it consumes that block's SCLK-edge strobes, loads a parallel transmit byte from the APB register block, shifts it out on MOSI and assembles the MISO byte. It returns the received word with a one-cycle completion pulse to the slave-select/status logic.

## Interface
- DATA_W, 8: transfer word width. Legal range is 2..16.
- PCLK  in  1  APB clock. All state is clocked on the rising edge.
- PRESETn  in  1  Asynchronous, active-low reset.
- ss  in  1  Active-low slave select from the slave-select controller.
- send_data  in  1  Load/start request. Single-cycle pulse.
- lsbfe  in  1  1 means LSB first; 0 means MSB first. Latched at load.
- cpol, cpha  in  1 each  SPI mode bits. Must be stable during a transfer.
- flag_low, flag_high  in  1 each  Sampling-edge strobes from the baud-rate generator.
- data_mosi  in  DATA_W  Transmit word from the data register.
- miso  in  1  Serial input from the slave.
- mosi  out  1  Serial output to the slave.
- data_miso  out  DATA_W  Last completed received word.
- rx_done  out  1  One-cycle pulse when data_miso updates.
- busy  out  1  High while a transfer is in progress.

## Operation
- Sample strobe `stb` = (cpol ^ cpha) ? flag_high : flag_low. It is qualified by state SHIFT and ss == 0.
- FSM states:
  - IDLE: on send_data, go to SHIFT. On that transition: load tx_reg from data_mosi, latch lsbfe, clear bit_cnt and rx_reg, drive mosi with the first bit (bit 0 if lsbfe, otherwise bit DATA_W-1).
  - SHIFT, on each stb:
    - rx_reg captures miso. It shifts right with miso entering the MSB if lsbfe; otherwise it shifts left with miso entering the LSB.
    - tx_reg shifts the same direction, and mosi takes the next bit.
    - bit_cnt increments.
    - On the stb with bit_cnt == DATA_W-1, go to DONE.
  - SHIFT with ss == 1: abort. Go to IDLE, mosi = 0, no rx_done, data_miso unchanged.
  - DONE: one cycle. data_miso <= rx_reg, rx_done <= 1, go to IDLE.
- send_data outside IDLE is ignored. It is not queued.
- bit_cnt is $clog2(DATA_W)+1 bits wide and does not wrap within a transfer.
- mosi holds its value between strobes. After the last bit it holds that bit until the next load or abort.

## Timing
- Reset values: mosi 0, data_miso 0, rx_done 0, busy 0, state IDLE, tx_reg/rx_reg/bit_cnt 0.
- Load: send_data sampled at edge N gives mosi = first bit and busy = 1 from N+1.
- Per bit: stb at edge K gives the next mosi bit visible from K+1. miso is sampled at edge K.
- Completion: the final stb at edge K gives DONE during K+1. At K+2, rx_done = 1 for exactly one cycle, data_miso is valid, and busy = 0.
- Load-to-done latency = DATA_W strobe intervals + 2 cycles.
- A send_data in the cycle rx_done is high is accepted (state is IDLE).
- Simultaneous stb and ss rising: the abort wins, and the sample is discarded.
- PRESETn asserted mid-transfer returns immediately to reset values. No rx_done.

## Configuration
- SPI_SHIFT_LOOPBACK_EN defined:
  - The miso used for sampling is replaced by the internal mosi. This is a self-test path.
  - The external miso is ignored.
  - mosi still drives the pin.
- SPI_SHIFT_LOOPBACK_EN undefined: the external miso is used. No loopback logic is present.

## Structure
- spi_pkg holds:
  - the state enum (IDLE, SHIFT, DONE) and its encoding localparams;
  - the default DATA_W;
  - the helper that computes bit_cnt width.
- One sub-module is natural: spi_edge_sel. It is a combinational mode-to-strobe select (cpol, cpha, flags in; stb out), shared with the slave-select controller.
- FSM, shift registers and counter stay in spi_shift_register.

## Test plan
- Mode 0, lsbfe = 0, data_mosi = 0xA5, miso pattern 1,0,0,1,0,1,1,0 on successive flag_low: mosi sequence is 1,0,1,0,0,1,0,1; data_miso = 0x96; rx_done pulses once, 2 cycles after the 8th strobe.
- Mode 3, lsbfe = 1, data_mosi = 0x01: mosi sequence is 1,0,0,0,0,0,0,0 on flag_low strobes; miso all ones gives data_miso = 0xFF.
- Mode 1, data_mosi = 0x3C: flag_low pulses are ignored. The transfer advances only on flag_high, and busy stays high until the 8th flag_high.
- ss raised after 4 strobes: state returns to IDLE next cycle, mosi = 0, no rx_done, data_miso keeps its previous value (0x96).
- send_data pulsed during SHIFT with a new data_mosi = 0xFF: it is ignored and the original byte completes. send_data in the rx_done cycle starts a new transfer.
- PRESETn low after 3 strobes: all outputs go to 0 asynchronously. With SPI_SHIFT_LOOPBACK_EN defined, data_mosi = 0x5A yields data_miso = 0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master serial data path:
// FSM state encoding, default word width and counter-width helper.
package spi_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    // One extra bit so the counter can reach DATA_W without wrapping.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_shift_register_if.sv
// Bus between the SPI shift register and its neighbours (register block,
// baud-rate generator, slave-select/status logic).
interface spi_shift_register_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              ss;
    logic              send_data;
    logic              lsbfe;
    logic              cpol;
    logic              cpha;
    logic              flag_low;
    logic              flag_high;
    logic [DATA_W-1:0] data_mosi;
    logic              miso;
    logic              mosi;
    logic [DATA_W-1:0] data_miso;
    logic              rx_done;
    logic              busy;

    modport master (
        output ss, send_data, lsbfe, cpol, cpha, flag_low, flag_high,
               data_mosi, miso,
        input  mosi, data_miso, rx_done, busy
    );

    modport slave (
        input  ss, send_data, lsbfe, cpol, cpha, flag_low, flag_high,
               data_mosi, miso,
        output mosi, data_miso, rx_done, busy
    );

endinterface

// File: rtl/spi_edge_sel.sv
// Mode-to-strobe select: picks the baud-generator flag that marks the
// sampling edge for the current SPI mode. Shared with the slave-select logic.
module spi_edge_sel (
    input  logic i_cpol,
    input  logic i_cpha,
    input  logic i_flag_low,
    input  logic i_flag_high,
    output logic o_stb
);

    assign o_stb = (i_cpol ^ i_cpha) ? i_flag_high : i_flag_low;

endmodule

// File: rtl/spi_shift_register.sv
// SPI master serial data path: loads a parallel word, shifts it out on MOSI
// and assembles MISO. Optional macro SPI_SHIFT_LOOPBACK_EN samples MOSI
// internally instead of the MISO pin (self-test).
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    spi_shift_register_if.slave   bus
);

    localparam int CNT_W = cnt_width(DATA_W);

    state_e            r_state;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lsbfe;
    logic              r_mosi;
    logic [DATA_W-1:0] r_data_miso;
    logic              r_rx_done;
    logic              r_busy;

    logic              w_stb_raw;
    logic              w_stb;
    logic              w_miso;

    spi_edge_sel u_edge_sel (
        .i_cpol      (bus.cpol),
        .i_cpha      (bus.cpha),
        .i_flag_low  (bus.flag_low),
        .i_flag_high (bus.flag_high),
        .o_stb       (w_stb_raw)
    );

    assign w_stb = w_stb_raw && (r_state == SHIFT) && !bus.ss;

`ifdef SPI_SHIFT_LOOPBACK_EN
    assign w_miso = r_mosi;
`else
    assign w_miso = bus.miso;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain tx/mosi updates.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_cnt       <= '0;
            r_lsbfe     <= 1'b0;
            r_mosi      <= 1'b0;
            r_data_miso <= '0;
            r_rx_done   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.send_data) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                        r_tx    <= bus.data_mosi;
                        r_lsbfe <= bus.lsbfe;
                        r_cnt   <= '0;
                        r_rx    <= '0;
                        r_mosi  <= bus.lsbfe ? bus.data_mosi[0] : bus.data_mosi[DATA_W-1];
                    end
                end
                SHIFT: begin
                    // Deselect aborts even when a strobe arrives the same cycle.
                    if (bus.ss) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_mosi  <= 1'b0;
                    end else if (w_stb) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_lsbfe) begin
                            r_rx <= {w_miso, r_rx[DATA_W-1:1]};
                            r_tx <= {1'b0, r_tx[DATA_W-1:1]};
                        end else begin
                            r_rx <= {r_rx[DATA_W-2:0], w_miso};
                            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_mosi <= r_lsbfe ? r_tx[1] : r_tx[DATA_W-2];
                        end
                    end
                end
                DONE: begin
                    r_data_miso <= r_rx;
                    r_rx_done   <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mosi      = r_mosi;
    assign bus.data_miso = r_data_miso;
    assign bus.rx_done   = r_rx_done;
    assign bus.busy      = r_busy;

endmodule
